// File: rtl/pacman_pkg.sv
// pacman_pkg: maze geometry, directions, start tiles and movement helpers for the game core
package pacman_pkg;
    localparam int MAZE_W = 28;
    localparam int MAZE_H = 31;
    localparam logic [3:0] DIR_R = 4'b0001;
    localparam logic [3:0] DIR_L = 4'b0010;
    localparam logic [3:0] DIR_U = 4'b0100;
    localparam logic [3:0] DIR_D = 4'b1000;
    localparam logic [6:0] PAC_X0 = 7'd14;
    localparam logic [5:0] PAC_Y0 = 6'd23;
    // ghost start tiles packed as {clyde, inky, pinky, blinky}
    localparam logic [27:0] GHOST_X0 = {7'd15, 7'd12, 7'd13, 7'd14};
    localparam logic [23:0] GHOST_Y0 = {6'd14, 6'd14, 6'd14, 6'd11};
    localparam logic [15:0] GHOST_ORDER = {DIR_R, DIR_D, DIR_L, DIR_U};
    localparam int H_OFFSET = 336;
    localparam int V_OFFSET = 27;
    localparam int CENTER_OFFSET = 7;

    function automatic logic is_wall(input logic [6:0] tx, input logic [5:0] ty);
        return tx == 7'd0 || tx == 7'(MAZE_W - 1) || ty == 6'd0 || ty == 6'(MAZE_H - 1)
            || (ty == 6'd12 && tx >= 7'd11 && tx <= 7'd16);
    endfunction

    function automatic logic [6:0] step_x(input logic [6:0] x, input logic [3:0] d);
        return d[0] ? x + 7'd1 : d[1] ? x - 7'd1 : x;
    endfunction

    function automatic logic [5:0] step_y(input logic [5:0] y, input logic [3:0] d);
        return d[2] ? y - 6'd1 : d[3] ? y + 6'd1 : y;
    endfunction

    function automatic logic [3:0] rev_dir(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    function automatic logic [7:0] manhattan(input logic [6:0] ax, input logic [5:0] ay,
                                             input logic [6:0] bx, input logic [5:0] by);
        logic [6:0] dx;
        logic [5:0] dy;
        dx = ax > bx ? ax - bx : bx - ax;
        dy = ay > by ? ay - by : by - ay;
        return {1'b0, dx} + {2'b0, dy};
    endfunction

    function automatic logic [6:0] clamp_x(input int v);
        return v < 1 ? 7'd1 : v > MAZE_W - 2 ? 7'(MAZE_W - 2) : 7'(v);
    endfunction

    function automatic logic [5:0] clamp_y(input int v);
        return v < 1 ? 6'd1 : v > MAZE_H - 2 ? 6'(MAZE_H - 2) : 6'(v);
    endfunction

    // greedy non-reversing choice; strict < keeps the earlier direction on ties
    function automatic logic [3:0] ghost_dir(input logic [6:0] gx, input logic [5:0] gy,
                                             input logic [3:0] gd,
                                             input logic [6:0] tx, input logic [5:0] ty);
        logic [3:0] best;
        logic [3:0] c;
        logic [7:0] best_d;
        logic [7:0] d;
        best = rev_dir(gd);
        best_d = 8'hff;
        for (int i = 0; i < 4; i++) begin
            c = GHOST_ORDER[4*i +: 4];
            d = manhattan(step_x(gx, c), step_y(gy, c), tx, ty);
            if (c != rev_dir(gd) && !is_wall(step_x(gx, c), step_y(gy, c)) && d < best_d) begin
                best = c;
                best_d = d;
            end
        end
        return best;
    endfunction
endpackage

// File: rtl/map_index_to_display_pos.sv
// map_index_to_display_pos: converts a maze tile index to the display pixel at the tile centre
module map_index_to_display_pos
    import pacman_pkg::*;
#(
    parameter int H_VISIBLE_START = H_OFFSET,
    parameter int V_VISIBLE_START = V_OFFSET,
    parameter int MOVE_TO_CENTER  = CENTER_OFFSET
)(
    input  logic [6:0]  tile_x,
    input  logic [5:0]  tile_y,
    output logic [10:0] pos_x,
    output logic [9:0]  pos_y
);
    assign pos_x = {tile_x, 4'b0} + 11'(H_VISIBLE_START + MOVE_TO_CENTER);
    assign pos_y = {tile_y, 4'b0} + 10'(V_VISIBLE_START + MOVE_TO_CENTER);
endmodule

// File: rtl/top_module_game_logic.sv
// top_module_game_logic: tile-based Pac-Man core moving Pac-Man and four ghosts and detecting capture
module top_module_game_logic
    import pacman_pkg::*;
#(
    parameter int MOVE_DIV        = 4,
    parameter int GHOST_DIV       = 2,
    parameter int H_VISIBLE_START = H_OFFSET,
    parameter int V_VISIBLE_START = V_OFFSET,
    parameter int MOVE_TO_CENTER  = CENTER_OFFSET
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        rbtn,
    input  logic        lbtn,
    input  logic        ubtn,
    input  logic        dbtn,
    output logic [10:0] pacman_pos_x,
    output logic [9:0]  pacman_pos_y,
    output logic [10:0] blinky_pos_x,
    output logic [9:0]  blinky_pos_y,
    output logic [10:0] pinky_pos_x,
    output logic [9:0]  pinky_pos_y,
    output logic [10:0] inky_pos_x,
    output logic [9:0]  inky_pos_y,
    output logic [10:0] clyde_pos_x,
    output logic [9:0]  clyde_pos_y,
    output logic        pacman_is_dead,
    output logic [3:0]  pacman_moving_dir_out
);
    logic [15:0] tick_cnt, ghost_cnt;
    logic        tick, ghost_step, dead;
    logic [6:0]  pac_x, pac_nx;
    logic [5:0]  pac_y, pac_ny;
    logic [3:0]  pac_dir, pac_nd, req;
    logic [6:0]  gx [4], ngx [4], tgt_x [4];
    logic [5:0]  gy [4], ngy [4], tgt_y [4];
    logic [3:0]  gd [4], nd [4];
    logic [3:0]  hit;
    logic [10:0] gpx [4];
    logic [9:0]  gpy [4];

    assign tick       = tick_cnt == 16'(MOVE_DIV - 1);
    assign ghost_step = tick && ghost_cnt == 16'(GHOST_DIV - 1);

    always_comb begin
        req    = rbtn ? DIR_R : lbtn ? DIR_L : ubtn ? DIR_U : dbtn ? DIR_D : 4'b0;
        pac_nd = (req != 4'b0 && !is_wall(step_x(pac_x, req), step_y(pac_y, req))) ? req : pac_dir;
        pac_nx = is_wall(step_x(pac_x, pac_nd), step_y(pac_y, pac_nd)) ? pac_x : step_x(pac_x, pac_nd);
        pac_ny = is_wall(step_x(pac_x, pac_nd), step_y(pac_y, pac_nd)) ? pac_y : step_y(pac_y, pac_nd);
        // targets use the pre-edge Pac-Man state, Blinky and Clyde positions
        tgt_x[0] = pac_x;
        tgt_y[0] = pac_y;
        tgt_x[1] = clamp_x(int'(pac_x) + (pac_dir[0] ? 4 : pac_dir[1] ? -4 : 0));
        tgt_y[1] = clamp_y(int'(pac_y) + (pac_dir[3] ? 4 : pac_dir[2] ? -4 : 0));
        tgt_x[2] = clamp_x(2 * int'(gx[0]) - int'(pac_x));
        tgt_y[2] = clamp_y(2 * int'(gy[0]) - int'(pac_y));
        tgt_x[3] = manhattan(gx[3], gy[3], pac_x, pac_y) > 8'd8 ? pac_x : 7'd1;
        tgt_y[3] = manhattan(gx[3], gy[3], pac_x, pac_y) > 8'd8 ? pac_y : 6'd29;
        for (int i = 0; i < 4; i++) begin
            nd[i]  = ghost_step ? ghost_dir(gx[i], gy[i], gd[i], tgt_x[i], tgt_y[i]) : gd[i];
            ngx[i] = ghost_step ? step_x(gx[i], nd[i]) : gx[i];
            ngy[i] = ghost_step ? step_y(gy[i], nd[i]) : gy[i];
            hit[i] = (ngx[i] == pac_nx && ngy[i] == pac_ny)
                  || (ngx[i] == pac_x && ngy[i] == pac_y && pac_nx == gx[i] && pac_ny == gy[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt  <= '0;
            ghost_cnt <= '0;
            pac_x     <= PAC_X0;
            pac_y     <= PAC_Y0;
            pac_dir   <= DIR_R;
            dead      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                gx[i] <= GHOST_X0[7*i +: 7];
                gy[i] <= GHOST_Y0[6*i +: 6];
                gd[i] <= DIR_L;
            end
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
            if (tick && !dead) begin
                ghost_cnt <= ghost_step ? '0 : ghost_cnt + 16'd1;
                pac_x     <= pac_nx;
                pac_y     <= pac_ny;
                pac_dir   <= pac_nd;
                dead      <= |hit;
                for (int i = 0; i < 4; i++) begin
                    gx[i] <= ngx[i];
                    gy[i] <= ngy[i];
                    gd[i] <= nd[i];
                end
            end
        end
    end

    map_index_to_display_pos #(
        .H_VISIBLE_START(H_VISIBLE_START), .V_VISIBLE_START(V_VISIBLE_START), .MOVE_TO_CENTER(MOVE_TO_CENTER)
    ) u_pac_pos (.tile_x(pac_x), .tile_y(pac_y), .pos_x(pacman_pos_x), .pos_y(pacman_pos_y));

    for (genvar g = 0; g < 4; g++) begin : g_ghost_pos
        map_index_to_display_pos #(
            .H_VISIBLE_START(H_VISIBLE_START), .V_VISIBLE_START(V_VISIBLE_START), .MOVE_TO_CENTER(MOVE_TO_CENTER)
        ) u_pos (.tile_x(gx[g]), .tile_y(gy[g]), .pos_x(gpx[g]), .pos_y(gpy[g]));
    end

    assign blinky_pos_x = gpx[0];
    assign blinky_pos_y = gpy[0];
    assign pinky_pos_x  = gpx[1];
    assign pinky_pos_y  = gpy[1];
    assign inky_pos_x   = gpx[2];
    assign inky_pos_y   = gpy[2];
    assign clyde_pos_x  = gpx[3];
    assign clyde_pos_y  = gpy[3];
    assign pacman_is_dead        = dead;
    assign pacman_moving_dir_out = pac_dir;
endmodule

// File: tb/tb_top_module_game_logic.sv
// tb_top_module_game_logic: directed and randomized checks of the game core against a tile-level model
module tb_top_module_game_logic;
    localparam int MOVE_DIV  = 4;
    localparam int GHOST_DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rbtn = 1'b0, lbtn = 1'b0, ubtn = 1'b0, dbtn = 1'b0;
    logic [10:0] px [5];
    logic [9:0]  py [5];
    logic        dead;
    logic [3:0]  dir;
    logic [10:0] sx, sgx [4];
    logic [9:0]  sy, sgy [4];
    logic        sdead;
    logic [3:0]  sdir;
    int checks = 0;
    int errors = 0;

    // model state: index 0 is Pac-Man, 1..4 are blinky, pinky, inky, clyde; direction 0=R 1=L 2=U 3=D
    int mx [5], my [5], md [5];
    int mdead, mgc;
    int dxs [4] = '{1, -1, 0, 0};
    int dys [4] = '{0, 0, -1, 1};
    int ord [4] = '{2, 1, 3, 0};

    always #5 clk = ~clk;

    top_module_game_logic #(.MOVE_DIV(MOVE_DIV), .GHOST_DIV(GHOST_DIV)) dut (
        .clk(clk), .rst(rst), .rbtn(rbtn), .lbtn(lbtn), .ubtn(ubtn), .dbtn(dbtn),
        .pacman_pos_x(px[0]), .pacman_pos_y(py[0]),
        .blinky_pos_x(px[1]), .blinky_pos_y(py[1]),
        .pinky_pos_x(px[2]), .pinky_pos_y(py[2]),
        .inky_pos_x(px[3]), .inky_pos_y(py[3]),
        .clyde_pos_x(px[4]), .clyde_pos_y(py[4]),
        .pacman_is_dead(dead), .pacman_moving_dir_out(dir)
    );

    // ghosts effectively parked so Pac-Man can roam the maze undisturbed
    top_module_game_logic #(.MOVE_DIV(MOVE_DIV), .GHOST_DIV(1000)) slow (
        .clk(clk), .rst(rst), .rbtn(rbtn), .lbtn(lbtn), .ubtn(ubtn), .dbtn(dbtn),
        .pacman_pos_x(sx), .pacman_pos_y(sy),
        .blinky_pos_x(sgx[0]), .blinky_pos_y(sgy[0]),
        .pinky_pos_x(sgx[1]), .pinky_pos_y(sgy[1]),
        .inky_pos_x(sgx[2]), .inky_pos_y(sgy[2]),
        .clyde_pos_x(sgx[3]), .clyde_pos_y(sgy[3]),
        .pacman_is_dead(sdead), .pacman_moving_dir_out(sdir)
    );

    function automatic bit wall(input int x, input int y);
        return x == 0 || x == 27 || y == 0 || y == 30 || (y == 12 && x >= 11 && x <= 16);
    endfunction

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = '{14, 14, 13, 12, 15};
        my = '{23, 11, 14, 14, 14};
        md = '{0, 1, 1, 1, 1};
        mdead = 0;
        mgc = 0;
    endtask

    task automatic model_tick(input logic [3:0] b);
        int ox [5], oy [5], tx [5], ty [5];
        int opd, req, best, bd, d, nx, ny;
        bit far;
        if (mdead != 0) return;
        ox = mx;
        oy = my;
        opd = md[0];
        req = b[0] ? 0 : b[1] ? 1 : b[2] ? 2 : b[3] ? 3 : -1;
        if (req >= 0 && !wall(mx[0] + dxs[req], my[0] + dys[req])) md[0] = req;
        if (!wall(mx[0] + dxs[md[0]], my[0] + dys[md[0]])) begin
            mx[0] += dxs[md[0]];
            my[0] += dys[md[0]];
        end
        mgc++;
        if (mgc == GHOST_DIV) begin
            mgc = 0;
            tx[1] = ox[0];
            ty[1] = oy[0];
            tx[2] = clampi(ox[0] + 4 * dxs[opd], 1, 26);
            ty[2] = clampi(oy[0] + 4 * dys[opd], 1, 29);
            tx[3] = clampi(2 * ox[1] - ox[0], 1, 26);
            ty[3] = clampi(2 * oy[1] - oy[0], 1, 29);
            far = iabs(ox[4] - ox[0]) + iabs(oy[4] - oy[0]) > 8;
            tx[4] = far ? ox[0] : 1;
            ty[4] = far ? oy[0] : 29;
            for (int g = 1; g < 5; g++) begin
                best = md[g] ^ 1;
                bd = 1 << 30;
                for (int k = 0; k < 4; k++) begin
                    nx = ox[g] + dxs[ord[k]];
                    ny = oy[g] + dys[ord[k]];
                    d = iabs(nx - tx[g]) + iabs(ny - ty[g]);
                    if (ord[k] != (md[g] ^ 1) && !wall(nx, ny) && d < bd) begin
                        best = ord[k];
                        bd = d;
                    end
                end
                md[g] = best;
                mx[g] = ox[g] + dxs[best];
                my[g] = oy[g] + dys[best];
            end
        end
        for (int g = 1; g < 5; g++)
            if ((mx[g] == mx[0] && my[g] == my[0])
                || (mx[g] == ox[0] && my[g] == oy[0] && mx[0] == ox[g] && my[0] == oy[g]))
                mdead = 1;
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_x%0d", tag, i), px[i], mx[i] * 16 + 343);
            chk($sformatf("%s_y%0d", tag, i), py[i], my[i] * 16 + 34);
        end
        chk({tag, "_dir"}, dir, 1 << md[0]);
        chk({tag, "_dead"}, dead, mdead);
    endtask

    task automatic set_btn(input logic [3:0] b);
        {dbtn, ubtn, lbtn, rbtn} = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic do_tick(input string tag);
        repeat (MOVE_DIV) @(posedge clk);
        model_tick({dbtn, ubtn, lbtn, rbtn});
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pac_x"}, px[0], 567);
        chk({tag, "_pac_y"}, py[0], 402);
        chk({tag, "_blinky_x"}, px[1], 567);
        chk({tag, "_blinky_y"}, py[1], 210);
        chk({tag, "_pinky_x"}, px[2], 551);
        chk({tag, "_pinky_y"}, py[2], 258);
        chk({tag, "_inky_x"}, px[3], 535);
        chk({tag, "_inky_y"}, py[3], 258);
        chk({tag, "_clyde_x"}, px[4], 583);
        chk({tag, "_clyde_y"}, py[4], 258);
        chk({tag, "_dead"}, dead, 0);
        chk({tag, "_dir"}, dir, 1);
    endtask

    initial begin
        // reset values
        do_reset();
        chk_reset("reset");

        // right held: first move lands on the MOVE_DIV-th edge, then stops at tile 26
        set_btn(4'b0001);
        do_tick("right");
        chk("right_t1_x", px[0], 583);
        do_tick("right");
        chk("right_t2_x", px[0], 599);
        chk("right_t2_y", py[0], 402);
        repeat (12) do_tick("right");
        chk("right_stop_x", px[0], 759);
        chk("right_stop_dir", dir, 1);

        // blocked turns, observed on the instance with parked ghosts
        do_reset();
        repeat (3) do_tick("route_r");
        chk("slow_route_x", sx, 615);
        set_btn(4'b0100);
        repeat (22) do_tick("route_u");
        chk("slow_top_y", sy, 50);
        do_tick("route_u");
        chk("slow_blocked_y", sy, 50);
        chk("slow_blocked_x", sx, 615);
        chk("slow_blocked_dir", sdir, 4);
        set_btn(4'b0010);
        for (int i = 1; i <= 3; i++) begin
            do_tick("route_l");
            chk($sformatf("slow_left_x%0d", i), sx, 615 - 16 * i);
            chk("slow_left_dir", sdir, 2);
        end
        set_btn(4'b0100);
        do_tick("route_u2");
        chk("slow_up_refused_dir", sdir, 2);
        chk("slow_up_refused_x", sx, 551);
        chk("slow_up_refused_y", sy, 50);
        for (int g = 0; g < 4; g++) chk($sformatf("slow_ghost_x%0d", g), sgx[g], (g == 0 ? 14 : g == 1 ? 13 : g == 2 ? 12 : 15) * 16 + 343);
        chk("slow_alive", sdead, 0);

        // no buttons: the ghosts hunt down a parked Pac-Man, then everything freezes
        do_reset();
        set_btn(4'b0000);
        for (int t = 0; t < 300 && mdead == 0; t++) do_tick("chase");
        chk("chase_dead", dead, 1);
        for (int i = 0; i < 4; i++) begin
            repeat (25) @(posedge clk);
            @(negedge clk);
            check_model("frozen");
        end

        // reset asserted part-way through a tick clears counters and positions
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        chk_reset("midreset");
        repeat (MOVE_DIV - 1) @(posedge clk);
        @(negedge clk);
        chk("midreset_nomove_x", px[0], 567);
        @(posedge clk);
        model_tick(4'b0000);
        @(negedge clk);
        check_model("midreset_first");
        chk("midreset_first_x", px[0], 583);

        // random button play against the model
        for (int r = 0; r < 8; r++) begin
            do_reset();
            set_btn(4'($urandom_range(15)));
            for (int t = 0; t < 60; t++) begin
                if ($urandom_range(3) == 0) set_btn(4'($urandom_range(15)));
                do_tick("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/top_module_game_logic.md
Name: top_module_game_logic

Overview:
- Tile-based Pac-Man game core: reads four direction buttons, moves Pac-Man and four ghosts (Blinky, Pinky, Inky, Clyde) on a 28x31 tile maze, detects capture.
- Publishes each sprite's centre as a display pixel coordinate for the VGA renderer.
- Sits between the debounced button inputs and the sprite renderer.

Parameters:
- MOVE_DIV, 4: clock cycles per Pac-Man move tick (must be >=2).
- GHOST_DIV, 2: Pac-Man ticks per ghost step.
- H_VISIBLE_START, 336: first visible pixel column.
- V_VISIBLE_START, 27: first visible pixel row.
- MOVE_TO_CENTER, 7: offset from tile origin to tile centre.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- rbtn, lbtn, ubtn, dbtn  in  1 each  direction requests, level-sensitive
- pacman_pos_x, blinky_pos_x, pinky_pos_x, inky_pos_x, clyde_pos_x  out  11 each  centre pixel x
- pacman_pos_y, blinky_pos_y, pinky_pos_y, inky_pos_y, clyde_pos_y  out  10 each  centre pixel y
- pacman_is_dead  out  1  sticky capture flag
- pacman_moving_dir_out  out  4  Pac-Man current direction, one-hot

Behaviour:
- All state is registered on the clk rising edge. When rst==0 at an edge, reset applies.
- State is tile indices: x is 7 bits (0..27), y is 6 bits (0..30).
- Output mapping: pos_x = (tx<<4)+7+336; pos_y = (ty<<4)+7+27.
- Maze:
  - Wall iff tx==0, tx==27, ty==0 or ty==30.
  - Also wall: the ghost-house lid, ty==12 with 11<=tx<=16.
- Direction encoding: RIGHT=0001, LEFT=0010, UP=0100, DOWN=1000. Up is y-1.
- Reset values:
  - pacman (14,23) -> 567,402.
  - blinky (14,11) -> 567,210.
  - pinky (13,14) -> 551,258.
  - inky (12,14) -> 535,258.
  - clyde (15,14) -> 583,258.
  - pacman_is_dead=0, dir=0001, tick counter=0, ghost counter=0, all ghost directions=LEFT.
- Tick counter: runs 0..MOVE_DIV-1. A tick fires on the cycle it equals MOVE_DIV-1. Position registers update at that edge, so the first move is visible after the MOVE_DIV-th edge following reset release.
- Pac-Man on each tick:
  - Request is the highest-priority pressed button (r>l>u>d); none pressed = no request.
  - If the request exists and its neighbour tile is not a wall, dir becomes the request.
  - Then, if the neighbour in dir is not a wall, step one tile. Otherwise stay; dir is unchanged.
- Ghosts step on every GHOST_DIV-th tick (the same edge as Pac-Man's move). Targets:
  - Blinky: Pac-Man's tile.
  - Pinky: 4 tiles ahead of Pac-Man in dir, clamped to 1..26 / 1..29.
  - Inky: Pac-Man's tile mirrored through Blinky, clamped.
  - Clyde: Pac-Man's tile if Manhattan distance > 8, else (1,29).
- Ghost move choice:
  - Candidates: non-wall neighbours, excluding reversal of the ghost's own direction.
  - Pick the candidate minimising |dx|+|dy| to the target. Tie order: up, left, down, right.
  - If no candidate exists, reverse.
- Capture: any ghost's new tile equals Pac-Man's new tile, or the ghost and Pac-Man swapped tiles on this edge -> pacman_is_dead=1 at that edge.
- Once pacman_is_dead is set, all positions freeze until reset.
- Reset mid-tick restores all reset values and clears the counters.

Decomposition:
- Package pacman_pkg holds:
  - Direction localparams DIR_R/L/U/D.
  - Maze width/height (28, 31).
  - The is_wall(tx,ty) function.
  - Start tiles.
  - The offset constants.
- One combinational sub-module, map_index_to_display_pos (tile index -> pixel), instantiated 5 times.
- The bench-side inverse is display_pos_to_map_index: idx=(pos-336)>>4, (pos-27)>>4.

Test Plan:
- Reset: rst=0 two cycles -> pacman 567/402, blinky 567/210, dead=0, dir=0001.
- rbtn=1 after rst release, MOVE_DIV=4 -> pacman x=583 after the 4th edge, 599 after the 8th; y stays 402.
- rbtn held -> pacman stops at tile 26 (x=759) and dir stays 0001.
- Blocked-turn check:
  - At tile (14,1), press ubtn -> dir unchanged, no step.
  - Press lbtn -> dir=0010, x decreases by 16 per tick.
- No buttons pressed -> Blinky converges and sets dead=1 on the capture edge. Pac-Man and ghost positions then stay constant for 100 cycles.
- Head-on swap: place ghost and Pac-Man adjacent and moving toward each other -> dead=1 on that tick. Assert rst=0 mid-tick -> reset values restored next edge.
